// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor: opcodes, FSM states
// and the bit positions of the fields inside an 8-bit instruction word.
package proc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_J   = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALTED
    } state_e;

    localparam int OPC_MSB   = 7;
    localparam int OPC_LSB   = 6;
    localparam int RS_MSB    = 5;
    localparam int RS_LSB    = 4;
    localparam int RT_MSB    = 3;
    localparam int RT_LSB    = 2;
    localparam int RD_MSB    = 1;
    localparam int RD_LSB    = 0;
    localparam int IMM_W     = 2;
    localparam int REG_COUNT = 4;

endpackage

// File: rtl/proc_regfile.sv
// Four-entry register file: two asynchronous read ports, one synchronous
// write port. Reset loads each register with its own index so programs
// have small non-zero constants available without an immediate-load op.
module proc_regfile
    import proc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [1:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        raddr_a_i,
    input  logic [1:0]        raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];

    // Register storage: index-valued reset, single write port
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/proc_multicycle.sv
// Multicycle processor: FETCH -> EXEC -> (MEM) -> (WB) with a HALTED
// parking state. The FSM, ALU and data memory live here; the register
// file is a separate sub-module.
module proc_multicycle
    import proc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int DMEM_DEPTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              HALT,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_data,
    input  logic              imem_valid,
    output logic              wb_valid,
    output logic [1:0]        wb_idx,
    output logic [DATA_W-1:0] wb_data,
    output logic              neg_flag,
    output logic [ADDR_W-1:0] pc_out,
    output logic [1:0]        opcode_out,
    output logic              halted,
    output logic [15:0]       retired
);

    localparam int DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [7:0]         ir_q;
    logic [15:0]        retired_q;
    logic [DMEM_AW-1:0] maddr_q;
    logic               wb_valid_q;
    logic [1:0]         wb_idx_q;
    logic [DATA_W-1:0]  wb_data_q;
    logic               neg_flag_q;
    logic [DATA_W-1:0]  dmem_q [DMEM_DEPTH];

    opcode_e            opcode;
    logic [1:0]         rs_idx;
    logic [1:0]         rt_idx;
    logic [1:0]         rd_idx;
    logic [DATA_W-1:0]  rs_val;
    logic [DATA_W-1:0]  rt_val;
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W-1:0]  alu_res;
    logic [ADDR_W-1:0]  pc_seq;
    logic [ADDR_W-1:0]  pc_jump;

    assign opcode  = opcode_e'(ir_q[OPC_MSB:OPC_LSB]);
    assign rs_idx  = ir_q[RS_MSB:RS_LSB];
    assign rt_idx  = ir_q[RT_MSB:RT_LSB];
    assign rd_idx  = ir_q[RD_MSB:RD_LSB];
    assign imm_ext = {{(DATA_W-IMM_W){ir_q[RD_MSB]}}, ir_q[RD_MSB:RD_LSB]};
    assign alu_res = rs_val + ((opcode == OP_ADD) ? rt_val : imm_ext);
    assign pc_seq  = pc_q + ADDR_W'(1);
    assign pc_jump = pc_seq + {{(ADDR_W-IMM_W){ir_q[RD_MSB]}}, ir_q[RD_MSB:RD_LSB]};

    // The register write happens at the end of the WB cycle, using the
    // index/value already presented on the wb_* outputs.
    proc_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .we_i      (wb_valid_q),
        .waddr_i   (wb_idx_q),
        .wdata_i   (wb_data_q),
        .raddr_a_i (rs_idx),
        .raddr_b_i (rt_idx),
        .rdata_a_o (rs_val),
        .rdata_b_o (rt_val)
    );

    // Control FSM together with pc, IR, retire counter, write-back outputs and data memory
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            retired_q  <= '0;
            maddr_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
            neg_flag_q <= 1'b0;
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem_q[i] <= '0;
            end
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (HALT) begin
                        state_q <= ST_HALTED;
                    end else if (imem_valid) begin
                        ir_q    <= imem_data;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (opcode)
                        OP_ADD: begin
                            wb_valid_q <= 1'b1;
                            wb_idx_q   <= rd_idx;
                            wb_data_q  <= alu_res;
                            neg_flag_q <= alu_res[DATA_W-1];
                            state_q    <= ST_WB;
                        end
                        OP_LW, OP_SW: begin
                            maddr_q <= alu_res[DMEM_AW-1:0];
                            state_q <= ST_MEM;
                        end
                        OP_J: begin
                            pc_q      <= pc_jump;
                            retired_q <= retired_q + 16'd1;
                            state_q   <= ST_FETCH;
                        end
                        default: state_q <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (opcode == OP_SW) begin
                        dmem_q[maddr_q] <= rt_val;
                        pc_q            <= pc_seq;
                        retired_q       <= retired_q + 16'd1;
                        state_q         <= ST_FETCH;
                    end else begin
                        wb_valid_q <= 1'b1;
                        wb_idx_q   <= rt_idx;
                        wb_data_q  <= dmem_q[maddr_q];
                        neg_flag_q <= dmem_q[maddr_q][DATA_W-1];
                        state_q    <= ST_WB;
                    end
                end
                ST_WB: begin
                    pc_q      <= pc_seq;
                    retired_q <= retired_q + 16'd1;
                    state_q   <= ST_FETCH;
                end
                ST_HALTED: begin
                    if (!HALT) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign imem_req   = RST && !HALT && (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign wb_valid   = wb_valid_q;
    assign wb_idx     = wb_idx_q;
    assign wb_data    = wb_data_q;
    assign neg_flag   = neg_flag_q;
    assign pc_out     = pc_q;
    assign opcode_out = ir_q[OPC_MSB:OPC_LSB];
    assign halted     = (state_q == ST_HALTED);
    assign retired    = retired_q;

endmodule

// File: tb/tb_proc_multicycle.sv
// Self-checking bench for proc_multicycle: an instruction-level model of
// registers, data memory, pc and retire count predicts the outputs for
// every cycle; a negedge process compares them against the DUT.
module tb_proc_multicycle;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int DMEM_DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        HALT = 1'b0;
    logic        imem_valid = 1'b0;
    logic [7:0]  imem_data = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        wb_valid;
    logic [1:0]  wb_idx;
    logic [7:0]  wb_data;
    logic        neg_flag;
    logic [7:0]  pc_out;
    logic [1:0]  opcode_out;
    logic        halted;
    logic [15:0] retired;

    proc_multicycle #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DMEM_DEPTH (DMEM_DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .HALT       (HALT),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .wb_valid   (wb_valid),
        .wb_idx     (wb_idx),
        .wb_data    (wb_data),
        .neg_flag   (neg_flag),
        .pc_out     (pc_out),
        .opcode_out (opcode_out),
        .halted     (halted),
        .retired    (retired)
    );

    // Free-running clock, period 10
    always #5 CLK = ~CLK;

    int errCount = 0;
    int chkCount = 0;

    // Instruction-level architectural model
    logic [7:0]  mReg [4];
    logic [7:0]  mMem [16];
    logic [7:0]  mPc;
    logic [15:0] mRet;
    logic        mNeg;

    // Per-cycle expectations derived from the model
    bit          chkEn = 1'b0;
    bit          inRst = 1'b0;
    logic        eReq;
    logic [7:0]  ePc;
    logic [15:0] eRet;
    logic        eHalted;
    logic        eWbv;
    logic [1:0]  eWbIdx;
    logic [7:0]  eWbData;
    logic        eNeg;
    logic [1:0]  eOpc;
    bit          eOpcChk = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of DUT outputs against the expectations
    always @(negedge CLK) begin
        if (chkEn) begin
            if (inRst) begin
                checkOutput("imem_req_in_reset", {31'd0, imem_req}, 32'd0);
            end else begin
                checkOutput("imem_req", {31'd0, imem_req}, {31'd0, eReq});
                if (eReq) checkOutput("imem_addr", {24'd0, imem_addr}, {24'd0, ePc});
                checkOutput("pc_out", {24'd0, pc_out}, {24'd0, ePc});
                checkOutput("retired", {16'd0, retired}, {16'd0, eRet});
                checkOutput("halted", {31'd0, halted}, {31'd0, eHalted});
                checkOutput("wb_valid", {31'd0, wb_valid}, {31'd0, eWbv});
                checkOutput("neg_flag", {31'd0, neg_flag}, {31'd0, eNeg});
                if (eWbv) begin
                    checkOutput("wb_idx", {30'd0, wb_idx}, {30'd0, eWbIdx});
                    checkOutput("wb_data", {24'd0, wb_data}, {24'd0, eWbData});
                end
                if (eOpcChk) checkOutput("opcode_out", {30'd0, opcode_out}, {30'd0, eOpc});
            end
        end
    end

    task automatic modelReset();
        for (int i = 0; i < 4; i++) mReg[i] = 8'(i);
        for (int i = 0; i < 16; i++) mMem[i] = 8'h00;
        mPc  = 8'h00;
        mRet = 16'h0000;
        mNeg = 1'b0;
    endtask

    task automatic setFetchExpect();
        eReq    = 1'b1;
        ePc     = mPc;
        eRet    = mRet;
        eHalted = 1'b0;
        eWbv    = 1'b0;
        eNeg    = mNeg;
        eOpcChk = 1'b0;
    endtask

    // Holds reset low for two edges, then releases it and checks the reset state
    task automatic resetDut();
        chkEn      = 1'b1;
        inRst      = 1'b1;
        RST        = 1'b0;
        HALT       = 1'b0;
        imem_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST   = 1'b1;
        inRst = 1'b0;
        modelReset();
        setFetchExpect();
        checkOutput("rst_pc", {24'd0, pc_out}, 32'd0);
        checkOutput("rst_retired", {16'd0, retired}, 32'd0);
        checkOutput("rst_wb_idx", {30'd0, wb_idx}, 32'd0);
        checkOutput("rst_wb_data", {24'd0, wb_data}, 32'd0);
        checkOutput("rst_opcode", {30'd0, opcode_out}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    endtask

    // Serves one instruction fetch (after 'stall' idle cycles) and predicts its execution
    task automatic applyStimulus(input logic [7:0] inst, input int stall, input bit haltInExec);
        logic [1:0] op, rs, rt, rd, wbI;
        logic [7:0] imm8, sum, wbD;
        logic [3:0] addr;
        bit         wr;
        int         lat;
        op   = inst[7:6];
        rs   = inst[5:4];
        rt   = inst[3:2];
        rd   = inst[1:0];
        imm8 = {{6{inst[1]}}, inst[1:0]};
        wr   = 1'b0;
        wbI  = 2'd0;
        wbD  = 8'h00;
        addr = 4'h0;
        sum  = 8'h00;
        case (op)
            2'd0: begin sum = mReg[rs] + mReg[rt]; wr = 1'b1; wbI = rd; wbD = sum; lat = 3; end
            2'd1: begin sum = mReg[rs] + imm8; addr = sum[3:0]; wr = 1'b1; wbI = rt; wbD = mMem[addr]; lat = 4; end
            2'd2: begin sum = mReg[rs] + imm8; addr = sum[3:0]; lat = 3; end
            default: lat = 2;
        endcase
        HALT = 1'b0;
        setFetchExpect();
        for (int s = 0; s < stall; s++) begin
            imem_valid = 1'b0;
            imem_data  = 8'($urandom);
            @(posedge CLK); #1;
        end
        imem_valid = 1'b1;
        imem_data  = inst;
        @(posedge CLK); #1;
        for (int k = 1; k < lat; k++) begin
            imem_valid = 1'($urandom_range(0, 1));
            imem_data  = 8'($urandom);
            eReq       = 1'b0;
            eOpc       = op;
            eOpcChk    = 1'b1;
            if (k == 1 && haltInExec) HALT = 1'b1;
            if (wr && k == lat - 1) begin
                eWbv    = 1'b1;
                eWbIdx  = wbI;
                eWbData = wbD;
                eNeg    = wbD[7];
            end else begin
                eWbv = 1'b0;
            end
            @(posedge CLK); #1;
        end
        imem_valid = 1'b0;
        if (wr) begin
            mReg[wbI] = wbD;
            mNeg      = wbD[7];
        end
        if (op == 2'd2) mMem[addr] = mReg[rt];
        mPc  = (op == 2'd3) ? (mPc + 8'd1 + imm8) : (mPc + 8'd1);
        mRet = mRet + 16'd1;
        eReq = !HALT;
        ePc  = mPc;
        eRet = mRet;
        eWbv = 1'b0;
        eNeg = mNeg;
    endtask

    // Parks the core with HALT held high, then releases it
    task automatic haltSequence();
        eReq    = 1'b0;
        eHalted = 1'b0;
        eWbv    = 1'b0;
        @(posedge CLK); #1;
        eHalted = 1'b1;
        checkOutput("halt_halted", {31'd0, halted}, 32'd1);
        checkOutput("halt_req", {31'd0, imem_req}, 32'd0);
        @(posedge CLK); #1;
        HALT = 1'b0;
        @(posedge CLK); #1;
    endtask

    // Fetches an instruction, lets it run 'n' cycles, then resets mid-flight
    task automatic abortInstr(input logic [7:0] inst, input int n);
        setFetchExpect();
        imem_valid = 1'b1;
        imem_data  = inst;
        @(posedge CLK); #1;
        imem_valid = 1'b0;
        for (int k = 1; k < n; k++) begin
            eReq    = 1'b0;
            eOpc    = inst[7:6];
            eOpcChk = 1'b1;
            @(posedge CLK); #1;
        end
        resetDut();
    endtask

    // Directed program
    initial begin
        resetDut();

        // r3 = r1 + r2
        applyStimulus(8'b00_01_10_11, 0, 1'b0);
        checkOutput("add_wb_idx", {30'd0, wb_idx}, 32'd3);
        checkOutput("add_wb_data", {24'd0, wb_data}, 32'd3);
        checkOutput("add_pc", {24'd0, pc_out}, 32'd1);
        checkOutput("add_retired", {16'd0, retired}, 32'd1);

        // sw r3 -> mem[r0+1] after three idle fetch cycles, then lw r2 <- mem[1]
        applyStimulus(8'b10_00_11_01, 3, 1'b0);
        applyStimulus(8'b01_00_10_01, 0, 1'b0);
        checkOutput("lw_wb_idx", {30'd0, wb_idx}, 32'd2);
        checkOutput("lw_wb_data", {24'd0, wb_data}, 32'd3);

        // advance pc to 5, then jump by -1 (pc stays) and by +1
        applyStimulus(8'b00_00_00_00, 1, 1'b0);
        applyStimulus(8'b00_00_00_00, 0, 1'b0);
        applyStimulus(8'b11_00_00_11, 0, 1'b0);
        checkOutput("j_back_pc", {24'd0, pc_out}, 32'd5);
        checkOutput("j_back_retired", {16'd0, retired}, 32'd6);
        applyStimulus(8'b11_00_00_01, 2, 1'b0);
        checkOutput("j_fwd_pc", {24'd0, pc_out}, 32'd7);

        // build 127 in r3 by repeated double-and-increment, copy to r1, then r2 = r1 + r1
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'b00_11_11_11, 0, 1'b0);
            applyStimulus(8'b00_11_01_11, 0, 1'b0);
        end
        applyStimulus(8'b00_11_00_01, 0, 1'b0);
        checkOutput("r1_127", {24'd0, wb_data}, 32'd127);
        applyStimulus(8'b00_01_01_10, 0, 1'b0);
        checkOutput("add_254", {24'd0, wb_data}, 32'd254);
        checkOutput("neg_254", {31'd0, neg_flag}, 32'd1);

        // HALT raised during EXEC of an add: add retires, then core parks
        applyStimulus(8'b00_00_00_00, 0, 1'b1);
        haltSequence();
        applyStimulus(8'b00_00_00_00, 0, 1'b0);

        // walk pc to 255 with jumps, then an add wraps it to 0
        while (mPc != 8'd255) begin
            if (mPc == 8'd254) applyStimulus(8'b00_00_00_00, 0, 1'b0);
            else applyStimulus(8'b11_00_00_01, $urandom_range(0, 1), 1'b0);
        end
        applyStimulus(8'b00_00_00_00, 0, 1'b0);
        checkOutput("pc_wrap", {24'd0, pc_out}, 32'd0);

        // reset during EXEC of r3 = r3 + r3 discards it: r0 = r3 + r0 gives 3
        abortInstr(8'b00_11_11_11, 1);
        applyStimulus(8'b00_11_00_00, 0, 1'b0);
        checkOutput("abort_add", {24'd0, wb_data}, 32'd3);

        // reset during MEM of a sw discards the store: lw from mem[1] gives 0
        abortInstr(8'b10_00_11_01, 2);
        applyStimulus(8'b01_00_10_01, 0, 1'b0);
        checkOutput("abort_sw", {24'd0, wb_data}, 32'd0);

        chkEn = 1'b0;
        @(posedge CLK); #1;
        $display("Result: errors=%0d of %0d checks", errCount, chkCount);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/proc_multicycle.md
PROC_MULTICYCLE -- requirements
Module: proc_multicycle

Interface
REQ-001 Parameter DATA_W, default 8, datapath/register/data-memory word width (>=8).
REQ-002 Parameter ADDR_W, default 8, PC and instruction-address width.
REQ-003 Parameter DMEM_DEPTH, default 16, data-memory words (power of 2).
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
REQ-006 HALT  in  1  stop request, sampled only in FETCH.
REQ-007 imem_req  out  1  instruction fetch request.
REQ-008 imem_addr  out  ADDR_W  fetch address (= pc).
REQ-009 imem_data  in  8  instruction; valid only when imem_valid=1.
REQ-010 imem_valid  in  1  fetch completion strobe.
REQ-011 wb_valid  out  1  one-cycle pulse on register write.
REQ-012 wb_idx  out  2  register written.
REQ-013 wb_data  out  DATA_W  value written.
REQ-014 neg_flag  out  1  MSB of last wb_data.
REQ-015 pc_out  out  ADDR_W  current pc; opcode_out  out  2  opcode of latched instruction; halted  out  1  high in HALTED.
REQ-016 retired  out  16  retired-instruction counter.

Function
REQ-017 Encoding: [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd; imm = sign-extend([1:0]); opcodes 00 add, 01 lw, 10 sw, 11 j.
REQ-018 States: FETCH, EXEC, MEM, WB, HALTED.
REQ-019 FETCH: if HALT=1 -> HALTED, imem_req=0; else imem_req=1, imem_addr=pc held stable until the imem_valid cycle, which latches imem_data into IR -> EXEC.
REQ-020 imem_valid outside an active request is ignored.
REQ-021 EXEC: add/lw/sw compute ALU = rs + (add ? rt : imm), modulo 2^DATA_W; add -> WB; lw/sw -> MEM; j -> pc <= pc+1+imm (mod 2^ADDR_W), retired+1, -> FETCH.
REQ-022 MEM: dmem address = ALU[log2(DMEM_DEPTH)-1:0]; sw writes rt, pc+1, retired+1, -> FETCH; lw does a synchronous read -> WB.
REQ-023 WB: write rd (add) or rt (lw); wb_valid=1 for exactly this cycle; update neg_flag; pc+1, retired+1; -> FETCH.
REQ-024 Latency with imem_valid in the first FETCH cycle: j 2 cycles, add 3, sw 3, lw 4.
REQ-025 HALTED: stay while HALT=1; HALT=0 -> FETCH with pc unchanged; HALT never aborts an instruction in progress.
REQ-026 pc and retired wrap silently (ADDR_W and 16 bits respectively).
REQ-027 Register file: 4 x DATA_W, two async read ports, one sync write port; no hardwired zero register.

Reset
REQ-028 RST=0 at a clock edge: state FETCH, pc 0, IR 0, register i = i, all dmem words 0, retired 0, wb_valid 0, wb_idx 0, wb_data 0, neg_flag 0, halted 0.
REQ-029 imem_req is 0 during reset; reset mid-instruction discards it with no register or memory write.

Structure
REQ-030 Shared package proc_pkg: opcode enum (OP_ADD, OP_LW, OP_SW, OP_J), state enum, instruction field-position constants.
REQ-031 Sub-module proc_regfile (parametrised by DATA_W) for the register file; FSM, ALU and dmem live in proc_multicycle.

Verification
REQ-032 Release reset, imem_valid=1 immediately, inst 8'b00_01_10_11 -> wb_valid pulse 3 cycles later with wb_idx=3, wb_data=3; pc_out=1; retired=1.
REQ-033 At pc=5, j inst 8'b11_00_00_11 (imm=-1) -> pc_out stays 5, no wb_valid, retired increments.
REQ-034 sw 8'b10_00_11_01 then lw 8'b01_00_10_01 -> dmem[1]=3; wb_idx=2, wb_data=3, lw completes 4 cycles after its fetch.
REQ-035 imem_valid held low 3 cycles -> state FETCH, imem_req=1, imem_addr constant for all 3 cycles.
REQ-036 HALT=1 asserted during EXEC of an add -> add retires, then halted=1 and imem_req=0; HALT=0 -> fetch resumes at next pc.
REQ-037 ADDR_W=8, pc=255, add -> pc_out=0; DATA_W=8, r1=127 plus r1 -> wb_data=254, neg_flag=1.
